tile_sequencer: RTL and testbench

- Producer side of the mode-decode path. Accepts one matmul job with total reduction depth K and total output width N.
- Walks the job as a sequence of tiles, each at most TILE_K_MAX x TILE_N_MAX.
- For each tile, emits the ksize/nsize pair that the array mode decoder consumes, plus offsets and last flags for the fetch and accumulate logic.
- Sits between the job command interface and the decoder/operand-fetch stage.

---
 rtl/tile_sequencer.sv | 163 ++++++++++++++++
 tb/tb_tile_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_sequencer.sv
// tile_sequencer
//   Accepts one matmul job (reduction depth K, output width N) and walks it
//   as a sequence of tiles of at most TILE_K_MAX x TILE_N_MAX, K inner and
//   N outer. Each tile descriptor carries the ksize/nsize pair for the array
//   mode decoder plus offsets and last flags for fetch/accumulate logic.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   cmd_valid/ready   job request handshake, k_total/n_total job dimensions
//   tile_valid/ready  tile descriptor handshake
//   ksize, nsize      current tile depth / width (never 0 while valid)
//   k_off, n_off      offsets of the current tile within the job
//   last_k            final K slice of the current N column (accumulator flush)
//   last              final tile of the job
//   done              one-cycle pulse when the job completes
module tile_sequencer #(
    parameter int DIM_W      = 12,
    parameter int TILE_K_MAX = 16,
    parameter int TILE_N_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DIM_W-1:0] k_total,
    input  logic [DIM_W-1:0] n_total,
    output logic             tile_valid,
    input  logic             tile_ready,
    output logic [4:0]       ksize,
    output logic [4:0]       nsize,
    output logic [DIM_W-1:0] k_off,
    output logic [DIM_W-1:0] n_off,
    output logic             last_k,
    output logic             last,
    output logic             done
);

    localparam logic [DIM_W-1:0] TK = DIM_W'(TILE_K_MAX);
    localparam logic [DIM_W-1:0] TN = DIM_W'(TILE_N_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [DIM_W-1:0] k_tot, n_tot, k_tot_n, n_tot_n;
    logic [DIM_W-1:0] k_off_n, n_off_n;
    logic             valid_n, done_n;
    logic [4:0]       ksize_n, nsize_n;
    logic             last_k_n, last_n;

    // Remaining extent clamped to the tile limit. The result never exceeds
    // 31, so keeping only the low 5 bits is lossless.
    function automatic logic [4:0] clamp_size(input logic [DIM_W-1:0] rem,
                                              input logic [DIM_W-1:0] lim);
        logic [DIM_W-1:0] m;
        m = (rem > lim) ? lim : rem;
        return m[4:0];
    endfunction

    function automatic logic [DIM_W-1:0] widen(input logic [4:0] s);
        return {{(DIM_W-5){1'b0}}, s};
    endfunction

    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_n  = state;
        k_tot_n  = k_tot;
        n_tot_n  = n_tot;
        k_off_n  = k_off;
        n_off_n  = n_off;
        valid_n  = tile_valid;
        done_n   = 1'b0;
        ksize_n  = 5'd0;
        nsize_n  = 5'd0;
        last_k_n = 1'b0;
        last_n   = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    k_tot_n = k_total;
                    n_tot_n = n_total;
                    k_off_n = '0;
                    n_off_n = '0;
                    if ((k_total == '0) || (n_total == '0)) begin
                        state_n = FINISH;
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = EMIT;
                        valid_n = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (tile_ready) begin
                    if (last) begin
                        state_n = FINISH;
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                    end else if (last_k) begin
                        k_off_n = '0;
                        n_off_n = n_off + widen(nsize);
                    end else begin
                        k_off_n = k_off + widen(ksize);
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase

        // The descriptor for the next cycle is derived from the offsets it
        // will hold, so a stalled tile recomputes to the same values.
        if (valid_n) begin
            ksize_n  = clamp_size(k_tot_n - k_off_n, TK);
            nsize_n  = clamp_size(n_tot_n - n_off_n, TN);
            last_k_n = ((k_off_n + widen(ksize_n)) == k_tot_n);
            last_n   = last_k_n && ((n_off_n + widen(nsize_n)) == n_tot_n);
        end else begin
            k_off_n = '0;
            n_off_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            k_tot      <= '0;
            n_tot      <= '0;
            k_off      <= '0;
            n_off      <= '0;
            ksize      <= 5'd0;
            nsize      <= 5'd0;
            last_k     <= 1'b0;
            last       <= 1'b0;
            tile_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            k_tot      <= k_tot_n;
            n_tot      <= n_tot_n;
            k_off      <= k_off_n;
            n_off      <= n_off_n;
            ksize      <= ksize_n;
            nsize      <= nsize_n;
            last_k     <= last_k_n;
            last       <= last_n;
            tile_valid <= valid_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_tile_sequencer.sv
// Testbench for tile_sequencer: an expected-tile queue is built from the job
// dimensions with nested loops; a negedge monitor checks every presented
// descriptor, stall stability, done timing and stray done pulses.
module tb_tile_sequencer;

    localparam int DW = 12;
    localparam int TK = 16;
    localparam int TN = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] k_total = '0;
    logic [DW-1:0] n_total = '0;
    logic          tile_valid;
    logic          tile_ready = 1'b1;
    logic [4:0]    ksize, nsize;
    logic [DW-1:0] k_off, n_off;
    logic          last_k, last, done;

    tile_sequencer #(.DIM_W(DW), .TILE_K_MAX(TK), .TILE_N_MAX(TN)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .k_total(k_total), .n_total(n_total),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .ksize(ksize), .nsize(nsize), .k_off(k_off), .n_off(n_off),
        .last_k(last_k), .last(last), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ko; int no; int ks; int ns; int lk; int l;
    } tile_t;

    tile_t exp_q[$];
    int    checks = 0;
    int    fails  = 0;
    int    cyc    = 0;
    int    exp_done_cyc = -1;
    bit    job_active = 0;
    bit    bp_mode = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Model: K inner, N outer; size is the clamped remainder.
    task automatic build_job(input int k, input int n);
        tile_t t;
        if (k == 0 || n == 0) return;
        for (int no = 0; no < n; no += TN) begin
            for (int ko = 0; ko < k; ko += TK) begin
                t.ko = ko; t.no = no;
                t.ks = imin(TK, k - ko);
                t.ns = imin(TN, n - no);
                t.lk = (ko + t.ks == k) ? 1 : 0;
                t.l  = (t.lk == 1 && no + t.ns == n) ? 1 : 0;
                exp_q.push_back(t);
            end
        end
    endtask

    // tile_ready driver: always 1, or the 0,0,1 backpressure pattern.
    initial begin
        int bp_cnt;
        bp_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                tile_ready = (bp_cnt % 3 == 2);
                bp_cnt++;
            end else begin
                tile_ready = 1'b1;
                bp_cnt = 0;
            end
        end
    end

    // Compare process.
    initial begin
        bit    prev_stall;
        tile_t prev, t;
        prev_stall = 0;
        prev = '{0, 0, 0, 0, 0, 0};
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_stall = 0;
                continue;
            end
            if (cyc == exp_done_cyc) chk("done_timing", int'(done), 1);
            if (prev_stall) chk("valid_dropped", int'(tile_valid), 1);
            if (tile_valid) begin
                chk("cmd_ready_busy", int'(cmd_ready), 0);
                chk("ksize_nonzero", int'(ksize != 0), 1);
                chk("nsize_nonzero", int'(nsize != 0), 1);
                if (prev_stall) begin
                    chk("stall_k_off", int'(k_off), prev.ko);
                    chk("stall_n_off", int'(n_off), prev.no);
                    chk("stall_ksize", int'(ksize), prev.ks);
                    chk("stall_nsize", int'(nsize), prev.ns);
                end
                if (exp_q.size() == 0) begin
                    chk("extra_tile", 1, 0);
                end else begin
                    t = exp_q[0];
                    chk("k_off", int'(k_off), t.ko);
                    chk("n_off", int'(n_off), t.no);
                    chk("ksize", int'(ksize), t.ks);
                    chk("nsize", int'(nsize), t.ns);
                    chk("last_k", int'(last_k), t.lk);
                    chk("last", int'(last), t.l);
                    if (tile_ready) begin
                        void'(exp_q.pop_front());
                        if (t.l == 1) exp_done_cyc = cyc + 1;
                    end
                end
                prev.ko = int'(k_off); prev.no = int'(n_off);
                prev.ks = int'(ksize); prev.ns = int'(nsize);
                prev_stall = !tile_ready;
            end else begin
                prev_stall = 0;
            end
            if (done) begin
                chk("done_expected", int'(job_active), 1);
                chk("done_all_tiles", exp_q.size(), 0);
                job_active = 0;
            end
        end
    end

    task automatic start_job(input int k, input int n);
        build_job(k, n);
        job_active = 1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        k_total = DW'(k);
        n_total = DW'(n);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        chk("cmd_ready_idle", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        if (k != 0 && n != 0) begin
            chk("first_latency", int'(tile_valid), 1);
        end else begin
            chk("zero_done", int'(done), 1);
            chk("zero_no_tile", int'(tile_valid), 0);
        end
    endtask

    task automatic wait_job(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!job_active) break;
        end
        chk("job_timeout", int'(job_active), 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_tile_valid", int'(tile_valid), 0);
        chk("rst_ksize", int'(ksize), 0);
        chk("rst_nsize", int'(nsize), 0);
        chk("rst_k_off", int'(k_off), 0);
        chk("rst_n_off", int'(n_off), 0);
        chk("rst_last", int'(last_k) + int'(last), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b1;

        // Pin the model with hand-computed ragged-job values.
        build_job(40, 20);
        chk("model_count", exp_q.size(), 6);
        chk("model_t3_ks", exp_q[2].ks, 8);
        chk("model_t3_lk", exp_q[2].lk, 1);
        chk("model_t3_l", exp_q[2].l, 0);
        chk("model_t4_no", exp_q[3].no, 16);
        chk("model_t4_ns", exp_q[3].ns, 4);
        chk("model_t6_l", exp_q[5].l, 1);
        chk("model_t6_ko", exp_q[5].ko, 32);
        exp_q.delete();

        // Ragged job
        start_job(40, 20);
        wait_job(100);

        // Exact multiples
        build_job(32, 16);
        chk("model_exact_cnt", exp_q.size(), 2);
        exp_q.delete();
        start_job(32, 16);
        wait_job(100);

        // Single small tile
        start_job(5, 3);
        wait_job(100);

        // Zero dimension
        start_job(0, 7);
        @(negedge clk);
        #1;
        chk("zero_cmd_ready", int'(cmd_ready), 1);
        chk("zero_done_once", int'(done), 0);
        wait_job(10);

        // Backpressure, with a stray command mid-job
        bp_mode = 1;
        start_job(40, 20);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        k_total = DW'(5);
        n_total = DW'(3);
        @(negedge clk);
        chk("midjob_cmd_ready", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_job(200);
        bp_mode = 0;

        // Reset during the third tile
        bp_mode = 1;
        start_job(40, 20);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (tile_valid && exp_q.size() == 4) break;
        end
        chk("third_tile_reached", exp_q.size(), 4);
        rst = 1'b0;
        #1;
        chk("midrst_tile_valid", int'(tile_valid), 0);
        chk("midrst_cmd_ready", int'(cmd_ready), 1);
        chk("midrst_done", int'(done), 0);
        exp_q.delete();
        job_active = 0;
        exp_done_cyc = -1;
        bp_mode = 0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        start_job(5, 3);
        wait_job(100);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
